// File: rtl/obstacle_painter.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_painter
// Description : Rectangle-fill engine for the obstacle image memory. One
//               command streams one pixel write per cycle in row-major order.
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_painter #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       clear,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [2:0] color,
    output logic [7:0] mem_x,
    output logic [6:0] mem_y,
    output logic [2:0] mem_color,
    output logic       mem_wren,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] c_XMAX = 8'(WIDTH - 1);
    localparam logic [6:0] c_YMAX = 7'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;

    // Latched command
    logic [7:0] r_x0;
    logic [7:0] r_x1;
    logic [6:0] r_y0;
    logic [6:0] r_y1;
    logic       r_clear;

    // Normalised rectangle bounds used while filling
    logic [7:0] r_xl;
    logic [7:0] r_xh;
    logic [6:0] r_yh;

    logic [7:0] r_mem_x;
    logic [6:0] r_mem_y;
    logic [2:0] r_mem_color;
    logic       r_mem_wren;
    logic       r_busy;
    logic       r_done;

    logic [7:0] w_xl;
    logic [7:0] w_xh;
    logic [6:0] w_yl;
    logic [6:0] w_yh;
    logic [7:0] w_xmax_raw;
    logic [6:0] w_ymax_raw;
    logic       w_empty;

    // Corner normalisation and clipping; clear overrides everything.
    always_comb begin
        w_xl       = (r_x0 < r_x1) ? r_x0 : r_x1;
        w_xmax_raw = (r_x0 < r_x1) ? r_x1 : r_x0;
        w_yl       = (r_y0 < r_y1) ? r_y0 : r_y1;
        w_ymax_raw = (r_y0 < r_y1) ? r_y1 : r_y0;
        w_xh       = (w_xmax_raw > c_XMAX) ? c_XMAX : w_xmax_raw;
        w_yh       = (w_ymax_raw > c_YMAX) ? c_YMAX : w_ymax_raw;
        w_empty    = (w_xl > c_XMAX) || (w_yl > c_YMAX);
        if (r_clear) begin
            w_xl    = 8'd0;
            w_xh    = c_XMAX;
            w_yl    = 7'd0;
            w_yh    = c_YMAX;
            w_empty = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_x0        <= 8'd0;
            r_x1        <= 8'd0;
            r_y0        <= 7'd0;
            r_y1        <= 7'd0;
            r_clear     <= 1'b0;
            r_xl        <= 8'd0;
            r_xh        <= 8'd0;
            r_yh        <= 7'd0;
            r_mem_x     <= 8'd0;
            r_mem_y     <= 7'd0;
            r_mem_color <= 3'd0;
            r_mem_wren  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x0        <= x0;
                        r_x1        <= x1;
                        r_y0        <= y0;
                        r_y1        <= y1;
                        r_clear     <= clear;
                        r_mem_color <= clear ? 3'b000 : color;
                        r_busy      <= 1'b1;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_xl <= w_xl;
                    r_xh <= w_xh;
                    r_yh <= w_yh;
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_mem_x    <= w_xl;
                        r_mem_y    <= w_yl;
                        r_mem_wren <= 1'b1;
                        r_state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    // Row turn reloads x in the same edge, so no gap cycle.
                    if (r_mem_x < r_xh) begin
                        r_mem_x <= r_mem_x + 8'd1;
                    end else if (r_mem_y < r_yh) begin
                        r_mem_x <= r_xl;
                        r_mem_y <= r_mem_y + 7'd1;
                    end else begin
                        r_mem_wren <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_wren <= 1'b0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_x     = r_mem_x;
    assign mem_y     = r_mem_y;
    assign mem_color = r_mem_color;
    assign mem_wren  = r_mem_wren;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_painter.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_painter
// Description : Self-checking bench for obstacle_painter against a
//               rectangle-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_painter;

    localparam int c_W = 160;
    localparam int c_H = 120;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       clear;
    logic [7:0] x0;
    logic [7:0] x1;
    logic [6:0] y0;
    logic [6:0] y1;
    logic [2:0] color;
    logic [7:0] mem_x;
    logic [6:0] mem_y;
    logic [2:0] mem_color;
    logic       mem_wren;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int busy_cyc;
    int done_cnt;
    int done_idx;
    int first_wr;
    int seq_bad;
    bit gap;
    bit timeout;

    obstacle_painter #(.WIDTH(c_W), .HEIGHT(c_H)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .clear     (clear),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .color     (color),
        .mem_x     (mem_x),
        .mem_y     (mem_y),
        .mem_color (mem_color),
        .mem_wren  (mem_wren),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: list of pixels the command should paint, in row-major order.
    task automatic model(input int ax0, input int ax1, input int ay0, input int ay1,
                         input int acol, input bit aclr);
        int xl, xh, yl, yh, c;
        exp_q.delete();
        if (aclr) begin
            xl = 0; xh = c_W - 1; yl = 0; yh = c_H - 1; c = 0;
        end else begin
            xl = (ax0 < ax1) ? ax0 : ax1;
            xh = (ax0 < ax1) ? ax1 : ax0;
            yl = (ay0 < ay1) ? ay0 : ay1;
            yh = (ay0 < ay1) ? ay1 : ay0;
            if (xh > c_W - 1) xh = c_W - 1;
            if (yh > c_H - 1) yh = c_H - 1;
            c = acol;
        end
        if (xl > c_W - 1 || yl > c_H - 1) return;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                exp_q.push_back({8'(x), 7'(y), 3'(c)});
    endtask

    // Issue one command and record everything the DUT does until it is idle.
    task automatic run_cmd(input int ax0, input int ax1, input int ay0, input int ay1,
                           input int acol, input bit aclr, input int pulse_at);
        int cyc;
        int lim;
        bit wr_ended;
        model(ax0, ax1, ay0, ay1, acol, aclr);
        got_q.delete();
        busy_cyc = 0; done_cnt = 0; done_idx = -1; first_wr = -1;
        gap = 0; timeout = 0; wr_ended = 0;
        @(negedge clk);
        x0 = 8'(ax0); x1 = 8'(ax1); y0 = 7'(ay0); y1 = 7'(ay1);
        color = 3'(acol); clear = aclr; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        lim = exp_q.size() + 20;
        while (1) begin
            if (cyc >= lim) begin
                timeout = 1;
                break;
            end
            @(negedge clk);
            cyc++;
            if (cyc == pulse_at) begin
                start = 1'b1; clear = 1'b0;
                x0 = 8'($urandom); x1 = 8'($urandom);
                y0 = 7'($urandom); y1 = 7'($urandom); color = 3'($urandom);
            end else if (cyc == pulse_at + 1) begin
                start = 1'b0;
            end
            if (!busy) break;
            busy_cyc++;
            if (mem_wren) begin
                if (wr_ended) gap = 1;
                if (first_wr < 0) first_wr = cyc;
                got_q.push_back({mem_x, mem_y, mem_color});
            end else if (got_q.size() > 0) begin
                wr_ended = 1;
            end
            if (done) begin
                done_cnt++;
                done_idx = cyc;
            end
        end
        start = 1'b0;
        seq_bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (seq_bad < 0 && got_q[i] !== exp_q[i]) seq_bad = i;
        if (seq_bad < 0 && got_q.size() != exp_q.size())
            seq_bad = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; clear = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({mem_x, mem_y, mem_color, mem_wren, busy, done} !== 21'd0) begin
            fails++;
            $display("FAIL reset_state: got x=%0d y=%0d c=%0d wren=%b busy=%b done=%b, expected all 0",
                     mem_x, mem_y, mem_color, mem_wren, busy, done);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({mem_wren, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL idle_no_start: got wren=%b busy=%b done=%b, expected 000", mem_wren, busy, done);
        end
    endtask

    task automatic test_single_pixel();
        run_cmd(5, 5, 7, 7, 2, 0, 0);
        tests++;
        if (got_q.size() !== 1 || got_q[0] !== {8'd5, 7'd7, 3'b010}) begin
            fails++;
            $display("FAIL single_write: got %0d writes first=%h, expected 1 write %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0, {8'd5, 7'd7, 3'b010});
        end
        tests++;
        if (busy_cyc !== 3) begin
            fails++;
            $display("FAIL single_busy: got %0d busy cycles, expected 3", busy_cyc);
        end
        tests++;
        if (done_cnt !== 1 || done_idx !== 3 || first_wr !== 2) begin
            fails++;
            $display("FAIL single_timing: got done_cnt=%0d done_idx=%0d first_wr=%0d, expected 1 3 2",
                     done_cnt, done_idx, first_wr);
        end
    endtask

    task automatic test_swapped();
        run_cmd(12, 10, 4, 3, 4, 0, 0);
        tests++;
        if (got_q.size() !== 6 || seq_bad !== -1) begin
            fails++;
            $display("FAIL swapped_seq: got %0d writes first bad idx %0d, expected 6 writes in order",
                     got_q.size(), seq_bad);
        end
        tests++;
        if (gap !== 1'b0 || done_idx !== 8 || busy_cyc !== 8) begin
            fails++;
            $display("FAIL swapped_timing: got gap=%b done_idx=%0d busy=%0d, expected 0 8 8",
                     gap, done_idx, busy_cyc);
        end
    endtask

    task automatic test_clipping();
        run_cmd(158, 255, 118, 127, 5, 0, 0);
        tests++;
        if (got_q.size() !== 4 || seq_bad !== -1) begin
            fails++;
            $display("FAIL clip_seq: got %0d writes first bad idx %0d, expected 4", got_q.size(), seq_bad);
        end
        tests++;
        if (got_q.size() > 0 && got_q[got_q.size()-1] !== {8'd159, 7'd119, 3'd5}) begin
            fails++;
            $display("FAIL clip_last: got %h, expected %h", got_q[got_q.size()-1], {8'd159, 7'd119, 3'd5});
        end
        run_cmd(200, 200, 10, 20, 3, 0, 0);
        tests++;
        if (got_q.size() !== 0 || busy_cyc !== 2 || done_idx !== 2 || done_cnt !== 1) begin
            fails++;
            $display("FAIL empty_rect: got writes=%0d busy=%0d done_idx=%0d done_cnt=%0d, expected 0 2 2 1",
                     got_q.size(), busy_cyc, done_idx, done_cnt);
        end
    endtask

    task automatic test_clear();
        run_cmd(37, 90, 5, 66, 7, 1, 0);
        tests++;
        if (got_q.size() !== 19200 || seq_bad !== -1) begin
            fails++;
            $display("FAIL clear_seq: got %0d writes first bad idx %0d, expected 19200", got_q.size(), seq_bad);
        end
        tests++;
        if (got_q.size() < 1 || got_q[0] !== 18'h0 || got_q[got_q.size()-1] !== {8'd159, 7'd119, 3'd0}) begin
            fails++;
            $display("FAIL clear_ends: got first/last not (0,0,0)/(159,119,0), writes=%0d", got_q.size());
        end
        tests++;
        if (busy_cyc !== 19202 || done_cnt !== 1 || gap !== 1'b0) begin
            fails++;
            $display("FAIL clear_timing: got busy=%0d done_cnt=%0d gap=%b, expected 19202 1 0",
                     busy_cyc, done_cnt, gap);
        end
    endtask

    task automatic test_start_ignored();
        run_cmd(20, 29, 40, 43, 6, 0, 7);
        tests++;
        if (got_q.size() !== 40 || seq_bad !== -1 || done_cnt !== 1 || busy_cyc !== 42) begin
            fails++;
            $display("FAIL start_ignored: got writes=%0d bad idx=%0d done_cnt=%0d busy=%0d, expected 40 -1 1 42",
                     got_q.size(), seq_bad, done_cnt, busy_cyc);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_ignored_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_fill();
        int spurious;
        @(negedge clk);
        x0 = 8'd0; x1 = 8'd50; y0 = 7'd0; y1 = 7'd10; color = 3'd3; clear = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (mem_wren !== 1'b1) begin
            fails++;
            $display("FAIL midfill_active: got wren=%b, expected 1", mem_wren);
        end
        resetn = 1'b0;
        #1;
        tests++;
        if (mem_wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midfill_reset: got wren=%b busy=%b done=%b, expected 000", mem_wren, busy, done);
        end
        @(negedge clk);
        resetn = 1'b1;
        spurious = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_wren || done || busy) spurious++;
        end
        tests++;
        if (spurious !== 0) begin
            fails++;
            $display("FAIL midfill_abandon: got %0d active cycles after reset, expected 0", spurious);
        end
        run_cmd(3, 6, 9, 10, 1, 0, 0);
        tests++;
        if (got_q.size() !== 8 || seq_bad !== -1 || done_cnt !== 1 || busy_cyc !== 10) begin
            fails++;
            $display("FAIL after_reset_cmd: got writes=%0d bad idx=%0d done_cnt=%0d busy=%0d, expected 8 -1 1 10",
                     got_q.size(), seq_bad, done_cnt, busy_cyc);
        end
    endtask

    task automatic test_random();
        int ax0, ax1, ay0, ay1, n;
        for (int it = 0; it < 30; it++) begin
            ax0 = $urandom_range(0, 255);
            ax1 = ax0 + $urandom_range(0, 14) - 7;
            if (ax1 < 0) ax1 = 0;
            if (ax1 > 255) ax1 = 255;
            ay0 = $urandom_range(0, 127);
            ay1 = ay0 + $urandom_range(0, 8) - 4;
            if (ay1 < 0) ay1 = 0;
            if (ay1 > 127) ay1 = 127;
            run_cmd(ax0, ax1, ay0, ay1, $urandom_range(0, 7), 0,
                    ($urandom_range(0, 1) == 1) ? 3 : 0);
            n = exp_q.size();
            tests++;
            if (timeout !== 1'b0 || seq_bad !== -1) begin
                fails++;
                $display("FAIL rand%0d_seq: got writes=%0d bad idx=%0d timeout=%b, expected %0d writes",
                         it, got_q.size(), seq_bad, timeout, n);
            end
            tests++;
            if (done_cnt !== 1 || done_idx !== n + 2 || busy_cyc !== n + 2 || gap !== 1'b0) begin
                fails++;
                $display("FAIL rand%0d_timing: got done_cnt=%0d done_idx=%0d busy=%0d gap=%b, expected 1 %0d %0d 0",
                         it, done_cnt, done_idx, busy_cyc, gap, n + 2, n + 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_swapped();
        test_clipping();
        test_clear();
        test_start_ignored();
        test_reset_mid_fill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
